// File: rtl/msg_word_packer.sv
// Byte-to-word packer: gathers message bytes MSB-lane first into WORD_BYTES-wide words with sop/eop/nbytes.
// Latency: a word is valid on the cycle after its completing byte (last byte of the word or of the message).
// Backpressure: byte_in_ready drops while a word is held unaccepted; the held word stays stable. MSG_WORD_PACKER_ZERO_PAD_EN zero-fills partial words.
module msg_word_packer #(
    parameter int WORD_BYTES = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            byte_in_valid,
    input  logic [7:0]                      byte_in_data,
    input  logic                            byte_in_last,
    output logic                            byte_in_ready,
    output logic                            msg_out_valid,
    output logic [8*WORD_BYTES-1:0]         msg_out_data,
    output logic                            msg_out_sop,
    output logic                            msg_out_eop,
    output logic [$clog2(WORD_BYTES):0]     msg_out_nbytes,
    input  logic                            msg_out_ready
);

    localparam int IDXW = $clog2(WORD_BYTES);
    localparam int NBW  = IDXW + 1;

    localparam logic [0:0] SOP_PENDING = 1'b0;
    localparam logic [0:0] MID_MSG     = 1'b1;

    logic [IDXW-1:0]         idx_q, idx_d;
    logic [8*WORD_BYTES-1:0] acc_q, acc_d;
    logic [8*WORD_BYTES-1:0] merged;
    logic [0:0]              state_q, state_d;
    logic                    valid_q, valid_d;
    logic [8*WORD_BYTES-1:0] data_q, data_d;
    logic                    sop_q, sop_d;
    logic                    eop_q, eop_d;
    logic [NBW-1:0]          nbytes_q, nbytes_d;
    logic                    accept;
    logic                    complete;

    // The output slot can take a new word whenever it is empty or draining this cycle;
    // reset is ORed in so the upstream sees ready even before valid_q is known.
    assign byte_in_ready = rst | ~valid_q | msg_out_ready;
    assign accept        = byte_in_valid & byte_in_ready;
    assign complete      = accept & (byte_in_last | (idx_q == IDXW'(WORD_BYTES - 1)));

    // Accumulator with the incoming byte dropped into lane idx_q (lane 0 is the MSB byte).
    always_comb begin
        merged = acc_q;
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (idx_q == IDXW'(i)) begin
                merged[8*(WORD_BYTES-1-i) +: 8] = byte_in_data;
            end
        end
    end

    // Next-state for accumulator, lane index, output register and sop FSM.
    always_comb begin
        acc_d    = acc_q;
        idx_d    = idx_q;
        state_d  = state_q;
        valid_d  = valid_q & ~msg_out_ready;
        data_d   = data_q;
        sop_d    = sop_q;
        eop_d    = eop_q;
        nbytes_d = nbytes_q;

        if (accept) begin
            acc_d = merged;
            idx_d = idx_q + IDXW'(1);
        end

        if (complete) begin
            idx_d    = '0;
`ifdef MSG_WORD_PACKER_ZERO_PAD_EN
            // Clearing here means lanes past the last byte of a partial word are already zero.
            acc_d    = '0;
`endif
            valid_d  = 1'b1;
            data_d   = merged;
            sop_d    = (state_q == SOP_PENDING);
            eop_d    = byte_in_last;
            nbytes_d = NBW'(idx_q) + NBW'(1);
            state_d  = byte_in_last ? SOP_PENDING : MID_MSG;
        end
    end

    // State registers; reset discards any partial or pending word.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            idx_q    <= '0;
            state_q  <= SOP_PENDING;
            valid_q  <= 1'b0;
            data_q   <= '0;
            sop_q    <= 1'b0;
            eop_q    <= 1'b0;
            nbytes_q <= '0;
        end else begin
            acc_q    <= acc_d;
            idx_q    <= idx_d;
            state_q  <= state_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            sop_q    <= sop_d;
            eop_q    <= eop_d;
            nbytes_q <= nbytes_d;
        end
    end

    assign msg_out_valid  = valid_q;
    assign msg_out_data   = data_q;
    assign msg_out_sop    = sop_q;
    assign msg_out_eop    = eop_q;
    assign msg_out_nbytes = nbytes_q;

endmodule

// File: tb/tb_msg_word_packer.sv
// Testbench for msg_word_packer (WORD_BYTES=4): scenario tasks push expected words, a monitor pops them on handshake.
// Latency: checks the one-cycle completing-byte to valid delay and bubble-free back-to-back words.
// Backpressure: holds msg_out_ready low to check stall stability and byte_in_ready deassertion.
module tb_msg_word_packer;

    typedef struct packed {
        logic [31:0] d;
        logic        sop;
        logic        eop;
        logic [2:0]  nb;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        byte_in_valid;
    logic [7:0]  byte_in_data;
    logic        byte_in_last;
    logic        byte_in_ready;
    logic        msg_out_valid;
    logic [31:0] msg_out_data;
    logic        msg_out_sop;
    logic        msg_out_eop;
    logic [2:0]  msg_out_nbytes;
    logic        msg_out_ready;

    int   vectors;
    int   miscompares;
    exp_t exp_q[$];

    msg_word_packer #(.WORD_BYTES(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .byte_in_valid  (byte_in_valid),
        .byte_in_data   (byte_in_data),
        .byte_in_last   (byte_in_last),
        .byte_in_ready  (byte_in_ready),
        .msg_out_valid  (msg_out_valid),
        .msg_out_data   (msg_out_data),
        .msg_out_sop    (msg_out_sop),
        .msg_out_eop    (msg_out_eop),
        .msg_out_nbytes (msg_out_nbytes),
        .msg_out_ready  (msg_out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Scoreboard: every output handshake must match the oldest expected word.
    always @(negedge clk) begin
        if (!rst && msg_out_valid === 1'b1 && msg_out_ready === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_word: got data=%h sop=%b eop=%b nbytes=%0d, expected no word",
                         msg_out_data, msg_out_sop, msg_out_eop, msg_out_nbytes);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if ({msg_out_data, msg_out_sop, msg_out_eop, msg_out_nbytes} !== e) begin
                    miscompares++;
                    $display("FAIL word: got data=%h sop=%b eop=%b nbytes=%0d, expected data=%h sop=%b eop=%b nbytes=%0d",
                             msg_out_data, msg_out_sop, msg_out_eop, msg_out_nbytes, e.d, e.sop, e.eop, e.nb);
                end
            end
        end
    end

    task automatic push_exp(input logic [31:0] d, input logic sop, input logic eop, input logic [2:0] nb);
        exp_t e;
        e.d = d; e.sop = sop; e.eop = eop; e.nb = nb;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        byte_in_valid = 1'b0;
        byte_in_last  = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Presents one byte and returns #1 after the edge on which it was accepted.
    task automatic send_byte(input logic [7:0] d, input logic l);
        logic rdy;
        int   n;
        n = 0;
        byte_in_valid = 1'b1;
        byte_in_data  = d;
        byte_in_last  = l;
        do begin
            @(negedge clk);
            rdy = byte_in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (rdy !== 1'b1 && n < 50);
        if (rdy !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: byte %h not accepted, ready=%b expected 1", d, rdy);
        end
    endtask

    task automatic idle();
        byte_in_valid = 1'b0;
        byte_in_last  = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d words outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        msg_out_ready = 1'b0;
        rst = 1'b1;
        byte_in_valid = 1'b0;
        byte_in_data  = 8'h00;
        byte_in_last  = 1'b0;
        @(negedge clk);
        vectors++;
        if (byte_in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready_during: got %b expected 1", byte_in_ready);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        msg_out_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if ({msg_out_valid, msg_out_sop, msg_out_eop, msg_out_nbytes, msg_out_data} !== 38'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got valid=%b sop=%b eop=%b nbytes=%0d data=%h expected all zero",
                     msg_out_valid, msg_out_sop, msg_out_eop, msg_out_nbytes, msg_out_data);
        end
        vectors++;
        if (byte_in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready_after: got %b expected 1", byte_in_ready);
        end
    endtask

    task automatic test_stream();
        do_reset();
        push_exp(32'h00010203, 1'b1, 1'b0, 3'd4);
        push_exp(32'h04050607, 1'b0, 1'b1, 3'd4);
        for (int i = 0; i < 8; i++) begin
            send_byte(8'(i), (i == 7));
            if (i == 3 || i == 7) begin
                vectors++;
                if (msg_out_valid !== 1'b1) begin
                    miscompares++;
                    $display("FAIL stream_latency: byte %0d valid=%b expected 1", i, msg_out_valid);
                end
            end
            if (i == 4) begin
                vectors++;
                if (msg_out_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL stream_valid_drop: valid=%b expected 0", msg_out_valid);
                end
            end
        end
        idle();
        drain();
    endtask

    task automatic test_single();
        do_reset();
        push_exp(32'hAB000000, 1'b1, 1'b1, 3'd1);
        send_byte(8'hAB, 1'b1);
        idle();
        drain();
    endtask

    task automatic test_partial();
        do_reset();
        push_exp(32'h11121314, 1'b1, 1'b0, 3'd4);
`ifdef MSG_WORD_PACKER_ZERO_PAD_EN
        push_exp(32'h15160000, 1'b0, 1'b1, 3'd2);
`else
        push_exp(32'h15161314, 1'b0, 1'b1, 3'd2);
`endif
        for (int i = 0; i < 6; i++) begin
            send_byte(8'h11 + 8'(i), (i == 5));
        end
        idle();
        drain();
    endtask

    task automatic test_stall();
        logic [31:0] nxt;
`ifdef MSG_WORD_PACKER_ZERO_PAD_EN
        nxt = 32'hD0000000;
`else
        nxt = 32'hD0C1C2C3;
`endif
        do_reset();
        msg_out_ready = 1'b0;
        push_exp(32'hC0C1C2C3, 1'b1, 1'b1, 3'd4);
        push_exp(nxt, 1'b1, 1'b1, 3'd1);
        for (int i = 0; i < 4; i++) begin
            send_byte(8'hC0 + 8'(i), (i == 3));
        end
        byte_in_data = 8'hD0;
        byte_in_last = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            vectors++;
            if (byte_in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_ready: cycle %0d got %b expected 0", c, byte_in_ready);
            end
            vectors++;
            if ({msg_out_valid, msg_out_data, msg_out_sop, msg_out_eop, msg_out_nbytes} !== {1'b1, 32'hC0C1C2C3, 1'b1, 1'b1, 3'd4}) begin
                miscompares++;
                $display("FAIL stall_hold: cycle %0d got valid=%b data=%h sop=%b eop=%b nbytes=%0d expected 1 c0c1c2c3 1 1 4",
                         c, msg_out_valid, msg_out_data, msg_out_sop, msg_out_eop, msg_out_nbytes);
            end
        end
        @(posedge clk);
        #1 msg_out_ready = 1'b1;
        send_byte(8'hD0, 1'b1);
        idle();
        vectors++;
        if (msg_out_valid !== 1'b1 || msg_out_data !== nxt) begin
            miscompares++;
            $display("FAIL stall_next: got valid=%b data=%h expected 1 %h", msg_out_valid, msg_out_data, nxt);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        do_reset();
        push_exp(32'hA0A1A2A3, 1'b1, 1'b1, 3'd4);
        for (int i = 0; i < 3; i++) begin
            send_byte(8'hE0 + 8'(i), 1'b0);
        end
        idle();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            send_byte(8'hA0 + 8'(i), (i == 3));
        end
        idle();
        drain();
    endtask

    task automatic test_back_to_back();
        do_reset();
        push_exp(32'hB0B1B2B3, 1'b1, 1'b1, 3'd4);
        push_exp(32'hB4B5B6B7, 1'b1, 1'b1, 3'd4);
        for (int i = 0; i < 8; i++) begin
            send_byte(8'hB0 + 8'(i), (i == 3 || i == 7));
            if (i == 3 || i == 7) begin
                vectors++;
                if (msg_out_valid !== 1'b1 || msg_out_sop !== 1'b1) begin
                    miscompares++;
                    $display("FAIL b2b_word: byte %0d valid=%b sop=%b expected 1 1", i, msg_out_valid, msg_out_sop);
                end
            end
        end
        idle();
        drain();
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_stream();
        test_single();
        test_partial();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
